// File: rtl/i2c_byte_master.sv
// Byte-level open-drain I2C master: one request runs START, {address,rw}, ACK,
// one data byte, ACK/NACK, STOP. Honours slave clock stretching in Q2.
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   enI2C             request, sampled while idle
//   rw                0 = write data byte, 1 = read data byte
//   address, data     slave address and write byte, latched on accept
//   busy              high from the cycle after accept until STOP completes
//   dataIn            last byte received by a read with an acked address
//   ackError          NACK on address, or on data during a write
//   scl, sda          open-drain bus lines (driven 0 or z)
module i2c_byte_master #(
  parameter int unsigned CLK_DIV = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enI2C,
  input  logic       rw,
  input  logic [6:0] address,
  input  logic [7:0] data,
  output logic       busy,
  output logic [7:0] dataIn,
  output logic       ackError,
  inout  wire        scl,
  inout  wire        sda
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       addr_q, addr_d;
  logic             rw_q, rw_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       data_in_q, data_in_d;
  logic             ack_error_q, ack_error_d;
  logic             busy_q, busy_d;
  logic             scl_low_q, scl_low_d;
  logic             sda_low_q, sda_low_d;

  logic             scl_in, sda_in;
  logic             tick, sample;
  logic [7:0]       abyte;
  logic [2:0]       bidx;

  assign scl      = scl_low_q ? 1'b0 : 1'bz;
  assign sda      = sda_low_q ? 1'b0 : 1'bz;
  assign scl_in   = scl;
  assign sda_in   = sda;
  assign busy     = busy_q;
  assign dataIn   = data_in_q;
  assign ackError = ack_error_q;

  // Sequencing, sampling, and next bus drive derived from the next phase
  always_comb begin
    state_d     = state_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    data_d      = data_q;
    rx_d        = rx_q;
    data_in_d   = data_in_q;
    ack_error_d = ack_error_q;
    tick        = 1'b0;
    sample      = (state_q != S_IDLE) && (qtr_q == 2'd3) && (cnt_q == '0);

    if (state_q == S_IDLE) begin
      if (enI2C) begin
        state_d     = S_START;
        addr_d      = address;
        rw_d        = rw;
        data_d      = data;
        ack_error_d = 1'b0;
        qtr_d       = 2'd0;
        bit_d       = 3'd0;
        cnt_d       = '0;
      end
    end else begin
      // A slave holding SCL low after release freezes the quarter
      if ((qtr_q == 2'd2) && !scl_in) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      if (sample) begin
        case (state_q)
          S_ADDR_ACK: if (sda_in) ack_error_d = 1'b1;
          S_DATA:     if (rw_q) rx_d = {rx_q[6:0], sda_in};
          S_DATA_ACK: if (!rw_q && sda_in) ack_error_d = 1'b1;
          default: ;
        endcase
      end

      if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          case (state_q)
            S_START: begin
              state_d = S_ADDR;
              bit_d   = 3'd0;
            end
            S_ADDR: begin
              if (bit_q == 3'd7) state_d = S_ADDR_ACK;
              bit_d = bit_q + 3'd1;
            end
            S_ADDR_ACK: begin
              state_d = ack_error_q ? S_STOP : S_DATA;
              bit_d   = 3'd0;
            end
            S_DATA: begin
              if (bit_q == 3'd7) state_d = S_DATA_ACK;
              bit_d = bit_q + 3'd1;
            end
            S_DATA_ACK: state_d = S_STOP;
            S_STOP: begin
              state_d = S_IDLE;
              // Publish a read byte only as the transaction ends
              if (rw_q && !ack_error_q) data_in_d = rx_q;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end

    abyte     = {addr_d, rw_d};
    bidx      = 3'd7 - bit_d;
    scl_low_d = 1'b0;
    sda_low_d = 1'b0;
    case (state_d)
      S_START: begin
        scl_low_d = (qtr_d == 2'd3);
        sda_low_d = (qtr_d != 2'd0);
      end
      S_ADDR: begin
        scl_low_d = (qtr_d < 2'd2);
        sda_low_d = !abyte[bidx];
      end
      S_DATA: begin
        scl_low_d = (qtr_d < 2'd2);
        sda_low_d = !rw_d && !data_d[bidx];
      end
      S_ADDR_ACK, S_DATA_ACK: scl_low_d = (qtr_d < 2'd2);
      S_STOP: begin
        scl_low_d = (qtr_d < 2'd2);
        sda_low_d = (qtr_d != 2'd3);
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      qtr_q       <= 2'd0;
      bit_q       <= 3'd0;
      cnt_q       <= '0;
      addr_q      <= 7'd0;
      rw_q        <= 1'b0;
      data_q      <= 8'd0;
      rx_q        <= 8'd0;
      data_in_q   <= 8'd0;
      ack_error_q <= 1'b0;
      busy_q      <= 1'b0;
      scl_low_q   <= 1'b0;
      sda_low_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      data_q      <= data_d;
      rx_q        <= rx_d;
      data_in_q   <= data_in_d;
      ack_error_q <= ack_error_d;
      busy_q      <= busy_d;
      scl_low_q   <= scl_low_d;
      sda_low_q   <= sda_low_d;
    end
  end

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Byte-level open-drain I2C master sitting directly downstream of the touch/clock I2C controller.
- Consumes its `enI2C`/`rw`/`address`/`data` request and returns `busy` plus the received byte on `dataIn`. Every falling edge of `busy` marks one completed byte transaction.
- Each accepted request runs one complete bus transaction: START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.
- Drives the touch controller and RTC over shared SCL/SDA, and honours slave clock stretching.

Parameters:
- CLK_DIV, 30, system clocks per quarter SCL bit period (48 MHz / (4*30) = 400 kHz); legal range 2..65535.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- enI2C  input  1  transaction request; level-sensitive, sampled when busy=0.
- rw  input  1  0 = write data byte, 1 = read data byte.
- address  input  7  slave address.
- data  input  8  byte to transmit on write.
- busy  output  1  high from the cycle after accept until STOP completes.
- dataIn  output  8  last byte received on a read; holds value otherwise.
- ackError  output  1  NACK seen on address, or on data during a write.
- scl  inout  1  open drain: driven 0 or z, never 1.
- sda  inout  1  open drain: driven 0 or z, never 1.

Behaviour:
- Reset (asynchronous, while reset=0):
  - scl = z, sda = z, busy = 0, dataIn = 8'h00, ackError = 0.
  - State = IDLE; quarter counter = 0.
  - Lines release immediately on assertion, including mid-transaction. No STOP is generated.
- Accept:
  - At a posedge with state = IDLE and enI2C = 1, latch address, rw and data, clear ackError, and move to START.
  - busy = 1 from the next cycle.
  - Input changes while busy = 1 are ignored.
- Back-to-back: if enI2C is still 1 on the cycle busy returns 0, the next transaction is accepted on that edge. busy is therefore low for exactly 1 cycle between transactions.
- Timing:
  - The quarter tick fires every CLK_DIV clocks.
  - Each bit is 4 quarters:
    - Q0: SCL low, update SDA.
    - Q1: SCL low.
    - Q2: release SCL.
    - Q3: SCL high, sample SDA at the first clock of Q3.
- Clock stretching: in Q2, the quarter counter holds at 0 while scl reads 0 after release. Q3 starts only after scl is observed high.
- States and quarter counts:
  - IDLE.
  - START (4q): SDA low while SCL high, then SCL low.
  - ADDR (8 bits, 32q): {address, rw}, MSB first.
  - ADDR_ACK (4q): SDA released, sample.
  - DATA (8 bits, 32q):
    - Write: send data MSB first.
    - Read: SDA released, shift in MSB first.
  - DATA_ACK (4q):
    - Write: release SDA and sample the slave's ACK.
    - Read: master drives NACK (SDA z).
  - STOP (4q): SDA low, release SCL, then release SDA while SCL high.
  - Return to IDLE.
- Transaction length: the full transaction is 80 quarters. With no stretching, busy is high for exactly 80*CLK_DIV cycles.
- Address NACK (SDA = 1 in ADDR_ACK):
  - ackError = 1; go straight to STOP, skipping DATA.
  - busy is high for 44*CLK_DIV cycles; dataIn unchanged.
- Write data NACK: ackError = 1; transaction completes normally.
- Read: dataIn updates with the assembled byte on the cycle busy falls, never mid-byte. It holds until the next successful read.
- ackError holds its value until the next accept.
- SDA transitions occur only while SCL is low, except in START/STOP.
- Bus arbitration is not supported: single master.

Test Plan:
- CLK_DIV=2; write address 7'h38, data 8'h00, slave ACKs both → SDA bytes 8'h70 then 8'h00; START/STOP present; ackError=0; busy high exactly 160 cycles.
- CLK_DIV=2; read address 7'h38, slave returns 8'hA5 → byte 8'h71 on bus; master NACK on 9th data clock; dataIn=8'hA5 on the cycle busy falls.
- CLK_DIV=2; no slave on the bus (address NACK) → ackError=1; no data byte clocked; STOP issued; busy high 88 cycles; dataIn unchanged.
- CLK_DIV=2; slave holds SCL low 10 extra cycles during address bit 3 → busy duration 170 cycles; all bits identical to the unstretched case.
- enI2C held 1 for a write followed by 6 reads → 7 transactions; busy low for exactly 1 cycle between each; 7 busy falling edges.
- reset asserted mid-DATA → scl/sda = z, busy=0, ackError=0, dataIn=0 before the next clock edge. After release with enI2C=0, the state stays IDLE.
